// File: rtl/inference_rx_controller.sv
// Inference receive controller: accepts one addressed frame at a time, hands it
// to the accelerator with a one-cycle start pulse, guards the accelerator with
// a watchdog, and requests a reply frame carrying the classification result
// back to the sender. Every output is registered.
module inference_rx_controller #(
   parameter int USER_DATA_BYTES  = 785,
   parameter int DATA_FRAME_WIDTH = USER_DATA_BYTES * 8,
   parameter int IP_ADDR_WIDTH    = 32,
   parameter int MAC_ADDR_WIDTH   = 48,
   parameter int COUNTER_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES   = 65535
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic                        FRAME_READY,
   input  logic                        PACKET_FOR_ACCELERATOR,
   input  logic [DATA_FRAME_WIDTH-1:0] DATA_FRAME,
   input  logic [IP_ADDR_WIDTH-1:0]    SRC_IP_ADDRESS,
   input  logic [MAC_ADDR_WIDTH-1:0]   SRC_MAC_ADDRESS,
   output logic                        RX_ENABLE,
   output logic                        ACCEL_START,
   output logic [DATA_FRAME_WIDTH-1:0] ACCEL_DATA,
   input  logic                        ACCEL_DONE,
   input  logic [7:0]                  ACCEL_RESULT,
   output logic                        TX_REQ,
   output logic [IP_ADDR_WIDTH-1:0]    TX_DST_IP,
   output logic [MAC_ADDR_WIDTH-1:0]   TX_DST_MAC,
   output logic [7:0]                  TX_RESULT,
   input  logic                        TX_ACK,
   output logic [COUNTER_WIDTH-1:0]    FRAMES_ACCEPTED,
   output logic [COUNTER_WIDTH-1:0]    FRAMES_DROPPED,
   output logic [COUNTER_WIDTH-1:0]    TIMEOUTS
);

   // Watchdog only needs to reach TIMEOUT_CYCLES-1.
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]          WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_REPLY} state_t;

   state_t                        r_state;
   state_t                        w_next;
   logic                          w_capture;
   logic                          w_done;
   logic                          w_expire;
   logic                          w_drop;
   logic [WD_W-1:0]               r_wd;
   logic                          r_rx_enable;
   logic                          r_accel_start;
   logic                          r_tx_req;
   logic [DATA_FRAME_WIDTH-1:0]   r_accel_data;
   logic [IP_ADDR_WIDTH-1:0]      r_tx_dst_ip;
   logic [MAC_ADDR_WIDTH-1:0]     r_tx_dst_mac;
   logic [7:0]                    r_tx_result;
   logic [COUNTER_WIDTH-1:0]      r_frames_accepted;
   logic [COUNTER_WIDTH-1:0]      r_frames_dropped;
   logic [COUNTER_WIDTH-1:0]      r_timeouts;

   // Any frame offered while a transaction is in flight is lost.
   assign w_drop = FRAME_READY && (r_state != S_IDLE);

   // Next-state and event decode; accelerator completion beats watchdog expiry.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_done    = 1'b0;
      w_expire  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (FRAME_READY && PACKET_FOR_ACCELERATOR) begin
               w_capture = 1'b1;
               w_next    = S_START;
            end
         end
         S_START: w_next = S_RUN;
         S_RUN: begin
            if (ACCEL_DONE) begin
               w_done = 1'b1;
               w_next = S_REPLY;
            end else if (r_wd == WD_LAST) begin
               w_expire = 1'b1;
               w_next   = S_IDLE;
            end
         end
         S_REPLY: begin
            if (TX_ACK) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register plus the state-derived handshake outputs, registered from
   // the next state so they line up with the state they describe.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         r_state       <= S_IDLE;
         r_rx_enable   <= 1'b0;
         r_accel_start <= 1'b0;
         r_tx_req      <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_rx_enable   <= (w_next == S_IDLE);
         r_accel_start <= (w_next == S_START);
         r_tx_req      <= (w_next == S_REPLY);
      end
   end

   // Watchdog: zero outside RUN, counts every cycle spent in RUN.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET)                                  r_wd <= '0;
      else if (r_state == S_RUN && w_next == S_RUN) r_wd <= r_wd + 1'b1;
      else                                          r_wd <= '0;
   end

   // Frame payload and reply addressing, held until the next accepted frame.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         r_accel_data <= '0;
         r_tx_dst_ip  <= '0;
         r_tx_dst_mac <= '0;
      end else if (w_capture) begin
         r_accel_data <= DATA_FRAME;
         r_tx_dst_ip  <= SRC_IP_ADDRESS;
         r_tx_dst_mac <= SRC_MAC_ADDRESS;
      end
   end

   // Classification result, latched when the accelerator reports completion.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET)     r_tx_result <= '0;
      else if (w_done) r_tx_result <= ACCEL_RESULT;
   end

   // Saturating event counters.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         r_frames_accepted <= '0;
         r_frames_dropped  <= '0;
         r_timeouts        <= '0;
      end else begin
         if (w_capture && r_frames_accepted != CNT_MAX)
            r_frames_accepted <= r_frames_accepted + 1'b1;
         if (w_drop && r_frames_dropped != CNT_MAX)
            r_frames_dropped <= r_frames_dropped + 1'b1;
         if (w_expire && r_timeouts != CNT_MAX)
            r_timeouts <= r_timeouts + 1'b1;
      end
   end

   assign RX_ENABLE       = r_rx_enable;
   assign ACCEL_START     = r_accel_start;
   assign ACCEL_DATA      = r_accel_data;
   assign TX_REQ          = r_tx_req;
   assign TX_DST_IP       = r_tx_dst_ip;
   assign TX_DST_MAC      = r_tx_dst_mac;
   assign TX_RESULT       = r_tx_result;
   assign FRAMES_ACCEPTED = r_frames_accepted;
   assign FRAMES_DROPPED  = r_frames_dropped;
   assign TIMEOUTS        = r_timeouts;

endmodule

// File: tb/tb_inference_rx_controller.sv
// Bench for inference_rx_controller: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_inference_rx_controller;

   localparam int UDB  = 8;
   localparam int DW   = UDB * 8;
   localparam int IPW  = 32;
   localparam int MACW = 48;
   localparam int CW   = 4;
   localparam int TO   = 100;
   localparam int CMAX = (1 << CW) - 1;

   localparam int P_IDLE  = 0;
   localparam int P_START = 1;
   localparam int P_RUN   = 2;
   localparam int P_REPLY = 3;

   logic            ACLK = 1'b0;
   logic            ARESET = 1'b0;
   logic            FRAME_READY = 1'b0;
   logic            PACKET_FOR_ACCELERATOR = 1'b0;
   logic [DW-1:0]   DATA_FRAME = '0;
   logic [IPW-1:0]  SRC_IP_ADDRESS = '0;
   logic [MACW-1:0] SRC_MAC_ADDRESS = '0;
   logic            RX_ENABLE;
   logic            ACCEL_START;
   logic [DW-1:0]   ACCEL_DATA;
   logic            ACCEL_DONE = 1'b0;
   logic [7:0]      ACCEL_RESULT = '0;
   logic            TX_REQ;
   logic [IPW-1:0]  TX_DST_IP;
   logic [MACW-1:0] TX_DST_MAC;
   logic [7:0]      TX_RESULT;
   logic            TX_ACK = 1'b0;
   logic [CW-1:0]   FRAMES_ACCEPTED;
   logic [CW-1:0]   FRAMES_DROPPED;
   logic [CW-1:0]   TIMEOUTS;

   inference_rx_controller #(
      .USER_DATA_BYTES (UDB),
      .DATA_FRAME_WIDTH(DW),
      .IP_ADDR_WIDTH   (IPW),
      .MAC_ADDR_WIDTH  (MACW),
      .COUNTER_WIDTH   (CW),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .ACLK                  (ACLK),
      .ARESET                (ARESET),
      .FRAME_READY           (FRAME_READY),
      .PACKET_FOR_ACCELERATOR(PACKET_FOR_ACCELERATOR),
      .DATA_FRAME            (DATA_FRAME),
      .SRC_IP_ADDRESS        (SRC_IP_ADDRESS),
      .SRC_MAC_ADDRESS       (SRC_MAC_ADDRESS),
      .RX_ENABLE             (RX_ENABLE),
      .ACCEL_START           (ACCEL_START),
      .ACCEL_DATA            (ACCEL_DATA),
      .ACCEL_DONE            (ACCEL_DONE),
      .ACCEL_RESULT          (ACCEL_RESULT),
      .TX_REQ                (TX_REQ),
      .TX_DST_IP             (TX_DST_IP),
      .TX_DST_MAC            (TX_DST_MAC),
      .TX_RESULT             (TX_RESULT),
      .TX_ACK                (TX_ACK),
      .FRAMES_ACCEPTED       (FRAMES_ACCEPTED),
      .FRAMES_DROPPED        (FRAMES_DROPPED),
      .TIMEOUTS              (TIMEOUTS)
   );

   always #5 ACLK = ~ACLK;

   int n_chk  = 0;
   int n_pass = 0;
   int n_start = 0;
   int n_txreq = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // ---------------- reference model ----------------
   // Tracks which phase of a transaction we are in and how many RUN cycles
   // have elapsed; outputs follow from the phase entered at each edge.
   int              m_phase = P_IDLE;
   int              m_run   = 0;
   int              m_acc   = 0;
   int              m_drop  = 0;
   int              m_to    = 0;
   logic [DW-1:0]   m_data  = '0;
   logic [IPW-1:0]  m_ip    = '0;
   logic [MACW-1:0] m_mac   = '0;
   logic [7:0]      m_res   = '0;

   initial begin
      forever begin
         @(posedge ACLK or negedge ARESET);
         if (!ARESET) begin
            m_phase = P_IDLE; m_run = 0; m_acc = 0; m_drop = 0; m_to = 0;
            m_data = '0; m_ip = '0; m_mac = '0; m_res = '0;
         end else begin
            if (FRAME_READY && m_phase != P_IDLE) m_drop = sat(m_drop + 1);
            case (m_phase)
               P_IDLE: if (FRAME_READY && PACKET_FOR_ACCELERATOR) begin
                  m_data = DATA_FRAME; m_ip = SRC_IP_ADDRESS; m_mac = SRC_MAC_ADDRESS;
                  m_acc = sat(m_acc + 1);
                  m_phase = P_START;
               end
               P_START: begin m_phase = P_RUN; m_run = 0; end
               P_RUN: begin
                  m_run++;
                  if (ACCEL_DONE) begin m_res = ACCEL_RESULT; m_phase = P_REPLY; end
                  else if (m_run == TO) begin m_to = sat(m_to + 1); m_phase = P_IDLE; end
               end
               default: if (TX_ACK) m_phase = P_IDLE;
            endcase
         end
      end
   end

   // Expected handshake levels: RX_ENABLE stays low while reset is held.
   bit cmp_en = 0;
   bit m_rst_seen = 1;  // true while reset asserted and no edge since release

   initial begin
      forever begin
         @(posedge ACLK or negedge ARESET);
         m_rst_seen = !ARESET;
      end
   end

   // ---------------- compare process ----------------
   initial begin
      @(posedge ACLK);
      cmp_en = 1;
      forever begin
         @(negedge ACLK);
         chk("rx_enable",   RX_ENABLE,   (!m_rst_seen && m_phase == P_IDLE));
         chk("accel_start", ACCEL_START, (!m_rst_seen && m_phase == P_START));
         chk("tx_req",      TX_REQ,      (!m_rst_seen && m_phase == P_REPLY));
         chk("accel_data",  ACCEL_DATA,  m_data);
         chk("tx_dst_ip",   TX_DST_IP,   m_ip);
         chk("tx_dst_mac",  TX_DST_MAC,  m_mac);
         chk("tx_result",   TX_RESULT,   m_res);
         chk("accepted",    FRAMES_ACCEPTED, m_acc);
         chk("dropped",     FRAMES_DROPPED,  m_drop);
         chk("timeouts",    TIMEOUTS,        m_to);
         if (ACCEL_START === 1'b1) n_start++;
         if (TX_REQ === 1'b1)      n_txreq++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic quiet();
      FRAME_READY = 0; PACKET_FOR_ACCELERATOR = 0; ACCEL_DONE = 0; TX_ACK = 0;
   endtask

   task automatic do_reset();
      @(negedge ACLK);
      #2 ARESET = 0;
      quiet();
      @(negedge ACLK);
      chk("rst_rx_enable", RX_ENABLE, 0);
      chk("rst_start", ACCEL_START, 0);
      chk("rst_txreq", TX_REQ, 0);
      chk("rst_data", ACCEL_DATA, 0);
      chk("rst_ip", TX_DST_IP, 0);
      chk("rst_counters", {FRAMES_ACCEPTED, FRAMES_DROPPED, TIMEOUTS}, 0);
      @(negedge ACLK);
      #2 ARESET = 1;
      n_start = 0;
      n_txreq = 0;
   endtask

   // Offer one addressed frame; returns on the first cycle after capture.
   task automatic send_frame(input logic [DW-1:0] d, input logic [IPW-1:0] ip,
                             input logic [MACW-1:0] mac);
      @(negedge ACLK);
      FRAME_READY = 1; PACKET_FOR_ACCELERATOR = 1;
      DATA_FRAME = d; SRC_IP_ADDRESS = ip; SRC_MAC_ADDRESS = mac;
      @(negedge ACLK);
      FRAME_READY = 0; PACKET_FOR_ACCELERATOR = 0;
   endtask

   // Complete the in-flight transaction: done after done_dly cycles, ack
   // offered on the ack_wait-th reply cycle.
   task automatic finish_txn(input int done_dly, input logic [7:0] res, input int ack_wait,
                             input logic [IPW-1:0] ip, input logic [MACW-1:0] mac);
      repeat (done_dly) @(negedge ACLK);
      ACCEL_DONE = 1; ACCEL_RESULT = res;
      @(negedge ACLK);
      ACCEL_DONE = 0;
      for (int i = 1; i <= ack_wait; i++) begin
         if (i > 1) @(negedge ACLK);
         chk("reply_req", TX_REQ, 1);
         chk("reply_ip", TX_DST_IP, ip);
         chk("reply_mac", TX_DST_MAC, mac);
         chk("reply_res", TX_RESULT, res);
         if (i == ack_wait) TX_ACK = 1;
      end
      @(negedge ACLK);
      TX_ACK = 0;
      chk("reply_release", TX_REQ, 0);
      chk("reply_rx_back", RX_ENABLE, 1);
   endtask

   logic [DW-1:0] ones_fill;
   logic [DW-1:0] frame_b;

   initial begin
      for (int i = 0; i < UDB; i++) ones_fill[i*8 +: 8] = 8'h01;
      frame_b = {DW/8{8'hA5}};

      // Happy path
      do_reset();
      send_frame(ones_fill, 32'hcccccccc, 48'hdddddddddddd);
      chk("hp_start", ACCEL_START, 1);
      chk("hp_rx_low", RX_ENABLE, 0);
      finish_txn(50, 8'h07, 3, 32'hcccccccc, 48'hdddddddddddd);
      chk("hp_start_pulses", n_start, 1);
      chk("hp_req_cycles", n_txreq, 3);
      chk("hp_accepted", FRAMES_ACCEPTED, 1);
      chk("hp_model_acc", m_acc, 1);

      // Not for us
      do_reset();
      @(negedge ACLK);
      FRAME_READY = 1; PACKET_FOR_ACCELERATOR = 0;
      repeat (3) @(negedge ACLK);
      quiet();
      @(negedge ACLK);
      chk("nfu_start", n_start, 0);
      chk("nfu_counters", {FRAMES_ACCEPTED, FRAMES_DROPPED, TIMEOUTS}, 0);
      chk("nfu_rx", RX_ENABLE, 1);

      // Busy drop
      do_reset();
      send_frame(ones_fill, 32'h0a000001, 48'h112233445566);
      repeat (3) @(negedge ACLK);
      FRAME_READY = 1; PACKET_FOR_ACCELERATOR = 1;
      DATA_FRAME = frame_b; SRC_IP_ADDRESS = 32'h0b000002;
      @(negedge ACLK);
      quiet();
      @(negedge ACLK);
      chk("drop_count", FRAMES_DROPPED, 1);
      chk("drop_data", ACCEL_DATA, ones_fill);
      chk("drop_ip", TX_DST_IP, 32'h0a000001);
      finish_txn(5, 8'h3c, 1, 32'h0a000001, 48'h112233445566);

      // Timeout: no done for the whole watchdog window
      do_reset();
      send_frame(ones_fill, 32'h01020304, 48'h0);
      repeat (100) @(negedge ACLK);
      chk("to_before", TIMEOUTS, 0);
      chk("to_still_busy", RX_ENABLE, 0);
      @(negedge ACLK);
      chk("to_after", TIMEOUTS, 1);
      chk("to_idle", RX_ENABLE, 1);
      chk("to_no_req", n_txreq, 0);

      // Done on the last watchdog cycle wins
      do_reset();
      send_frame(ones_fill, 32'h05060708, 48'h0000beef0000);
      finish_txn(100, 8'h5a, 1, 32'h05060708, 48'h0000beef0000);
      chk("late_done_to", TIMEOUTS, 0);

      // TX backpressure
      do_reset();
      send_frame(frame_b, 32'hc0a80101, 48'hfeedfacecafe);
      finish_txn(10, 8'h11, 20, 32'hc0a80101, 48'hfeedfacecafe);
      chk("bp_req_cycles", n_txreq, 20);

      // Reset mid-RUN, then a clean transaction
      do_reset();
      send_frame(frame_b, 32'h11111111, 48'h222222222222);
      repeat (20) @(negedge ACLK);
      do_reset();
      @(negedge ACLK);
      chk("mid_rst_start", n_start, 0);
      send_frame(ones_fill, 32'hcccccccc, 48'hdddddddddddd);
      finish_txn(50, 8'h07, 3, 32'hcccccccc, 48'hdddddddddddd);
      chk("mid_rst_acc", FRAMES_ACCEPTED, 1);

      // Counter saturation
      do_reset();
      for (int i = 0; i < 17; i++) begin
         send_frame(DW'(i), IPW'(i), MACW'(i));
         finish_txn(1, 8'(i), 1, IPW'(i), MACW'(i));
      end
      chk("sat_acc", FRAMES_ACCEPTED, CMAX);
      send_frame(ones_fill, 32'h1, 48'h1);
      FRAME_READY = 1;
      repeat (30) @(negedge ACLK);
      FRAME_READY = 0;
      chk("sat_drop", FRAMES_DROPPED, CMAX);
      finish_txn(1, 8'h99, 1, 32'h1, 48'h1);

      // Random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(399) == 0) begin
            do_reset();
         end else begin
            @(negedge ACLK);
            FRAME_READY            = ($urandom_range(9) < 3);
            PACKET_FOR_ACCELERATOR = ($urandom_range(9) < 6);
            DATA_FRAME             = {$urandom, $urandom};
            SRC_IP_ADDRESS         = $urandom;
            SRC_MAC_ADDRESS        = {16'($urandom), $urandom};
            ACCEL_DONE             = ($urandom_range(39) == 0);
            ACCEL_RESULT           = 8'($urandom);
            TX_ACK                 = ($urandom_range(9) < 3);
         end
      end
      @(negedge ACLK);
      quiet();
      repeat (2) @(negedge ACLK);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
